// File: rtl/z_tile_ctrl.sv
// Depth-tile sequencer: clear sweep, then read/compare/write per pixel.
// Optional hit counters are enabled by defining ZTC_STATS_EN.
module z_tile_ctrl #(
  parameter int ADDR_W = 10,
  parameter int Z_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tile_start,
  input  logic              tile_clear,
  input  logic [Z_W-1:0]    clear_val,
  input  logic              tile_end,
  output logic              tile_done,
  output logic              busy,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [ADDR_W-1:0] px_addr,
  input  logic [Z_W-1:0]    px_z,
  input  logic              px_zwd,
  input  logic [2:0]        depth_comp,
  output logic              res_valid,
  output logic              res_pass,
  output logic [ADDR_W-1:0] res_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [Z_W-1:0]    rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [Z_W-1:0]    wr_data
`ifdef ZTC_STATS_EN
  ,
  output logic [31:0]       stat_pass,
  output logic [31:0]       stat_fail
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RASTER,
    DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t state;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [Z_W-1:0]    clr_data;

  logic              p_valid;
  logic [ADDR_W-1:0] p_addr;
  logic [Z_W-1:0]    p_z;
  logic              p_zwd;
  logic [2:0]        p_comp;

  logic              lw_valid;
  logic [ADDR_W-1:0] lw_addr;
  logic [Z_W-1:0]    lw_data;

  logic              accept;
  logic [Z_W-1:0]    old_z;
  logic              pass;

  assign accept = px_valid & px_ready;
  assign rd_addr = accept ? px_addr : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      px_ready  <= 1'b0;
      tile_done <= 1'b0;
      clr_we    <= 1'b0;
      clr_addr  <= '0;
      clr_data  <= '0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tile_start) begin
            busy     <= 1'b1;
            clr_data <= clear_val;
            clr_addr <= '0;
            if (tile_clear) begin
              state  <= CLEAR;
              clr_we <= 1'b1;
            end else begin
              state    <= RASTER;
              px_ready <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (clr_addr == LAST) begin
            clr_we   <= 1'b0;
            state    <= RASTER;
            px_ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        RASTER: begin
          if (tile_end) begin
            state    <= DRAIN;
            px_ready <= 1'b0;
          end
        end
        DRAIN: begin
          state     <= IDLE;
          busy      <= 1'b0;
          tile_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_valid  <= 1'b0;
      p_addr   <= '0;
      p_z      <= '0;
      p_zwd    <= 1'b0;
      p_comp   <= '0;
      lw_valid <= 1'b0;
      lw_addr  <= '0;
      lw_data  <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        p_addr <= px_addr;
        p_z    <= px_z;
        p_zwd  <= px_zwd;
        p_comp <= depth_comp;
      end
      // RAM returns pre-write data on a same-edge collision
      lw_valid <= wr_en;
      if (wr_en) begin
        lw_addr <= wr_addr;
        lw_data <= wr_data;
      end
    end
  end

  assign old_z = (lw_valid && lw_addr == p_addr)
               ? lw_data : rd_data;

  always_comb begin
    pass = 1'b0;
    case (p_comp)
      3'd0:    pass = 1'b0;
      3'd1:    pass = p_z <  old_z;
      3'd2:    pass = p_z == old_z;
      3'd3:    pass = p_z <= old_z;
      3'd4:    pass = p_z >  old_z;
      3'd5:    pass = p_z != old_z;
      3'd6:    pass = p_z >= old_z;
      default: pass = 1'b1;
    endcase
  end

  assign res_valid = p_valid;
  assign res_pass  = p_valid & pass;
  assign res_addr  = p_addr;
  assign wr_en     = clr_we | (p_valid & pass & ~p_zwd);
  assign wr_addr   = clr_we ? clr_addr : p_addr;
  assign wr_data   = clr_we ? clr_data : p_z;

`ifdef ZTC_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_pass <= '0;
      stat_fail <= '0;
    end else if (state == IDLE && tile_start) begin
      stat_pass <= '0;
      stat_fail <= '0;
    end else if (p_valid) begin
      if (pass && stat_pass != '1)
        stat_pass <= stat_pass + 1'b1;
      if (!pass && stat_fail != '1)
        stat_fail <= stat_fail + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_z_tile_ctrl.sv
// Bench for z_tile_ctrl: RAM model, sequential depth-buffer
// reference and per-cycle output compare.
module tb_z_tile_ctrl;
  localparam int AW = 10;
  localparam int ZW = 32;
  localparam int N  = 1 << AW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, tile_start, tile_clear, tile_end;
  logic [ZW-1:0] clear_val;
  logic          tile_done, busy;
  logic          px_valid, px_ready, px_zwd;
  logic [AW-1:0] px_addr;
  logic [ZW-1:0] px_z;
  logic [2:0]    depth_comp;
  logic          res_valid, res_pass;
  logic [AW-1:0] res_addr, rd_addr, wr_addr;
  logic [ZW-1:0] rd_data, wr_data;
  logic          wr_en;
`ifdef ZTC_STATS_EN
  logic [31:0]   stat_pass, stat_fail;
`endif

  z_tile_ctrl #(.ADDR_W(AW), .Z_W(ZW)) dut (
    .clock(clock), .reset(reset),
    .tile_start(tile_start), .tile_clear(tile_clear),
    .clear_val(clear_val), .tile_end(tile_end),
    .tile_done(tile_done), .busy(busy),
    .px_valid(px_valid), .px_ready(px_ready),
    .px_addr(px_addr), .px_z(px_z), .px_zwd(px_zwd),
    .depth_comp(depth_comp),
    .res_valid(res_valid), .res_pass(res_pass),
    .res_addr(res_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef ZTC_STATS_EN
    ,
    .stat_pass(stat_pass), .stat_fail(stat_fail)
`endif
  );

  // dual-port RAM, read-old-data on collision
  logic [ZW-1:0] ram [N];
  always @(posedge clock) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    rd_data <= ram[rd_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic          p;
    logic          w;
    logic [ZW-1:0] z;
  } exp_t;

  exp_t          q[$];
  logic [ZW-1:0] zm [N];
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            armed = 0;
  bit            clr_on = 0;
  int            clr_from, clr_idx;
  logic [ZW-1:0] clr_v;
  int            ep = 0;
  int            ef = 0;

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic bit zpass(logic [2:0] c,
                               logic [ZW-1:0] n,
                               logic [ZW-1:0] o);
    case (c)
      3'd0: return 1'b0;
      3'd1: return n < o;
      3'd2: return n == o;
      3'd3: return n <= o;
      3'd4: return n > o;
      3'd5: return n != o;
      3'd6: return n >= o;
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clock) begin
    if (armed) begin
      while (q.size() > 0 && q[0].c < cyc) begin
        chk("missed_result", 32'(q[0].a), 32'hFFFF_FFFF);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].c == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("res_valid", 32'(res_valid), 1);
        chk("res_pass", 32'(res_pass), 32'(e.p));
        chk("res_addr", 32'(res_addr), 32'(e.a));
        chk("px_wr_en", 32'(wr_en), 32'(e.w));
        if (e.w) begin
          chk("px_wr_addr", 32'(wr_addr), 32'(e.a));
          chk("px_wr_data", wr_data, e.z);
        end
      end else begin
        chk("idle_res_valid", 32'(res_valid), 0);
        if (clr_on && cyc >= clr_from) begin
          chk("clr_wr_en", 32'(wr_en), 1);
          chk("clr_wr_addr", 32'(wr_addr), clr_idx);
          chk("clr_wr_data", wr_data, clr_v);
          clr_idx++;
          if (clr_idx == N) clr_on = 0;
        end else begin
          chk("idle_wr_en", 32'(wr_en), 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start(bit clr, logic [ZW-1:0] v);
    tile_start = 1'b1;
    tile_clear = clr;
    clear_val  = v;
    if (clr) begin
      clr_on   = 1;
      clr_from = cyc + 1;
      clr_idx  = 0;
      clr_v    = v;
      for (int i = 0; i < N; i++) zm[i] = v;
    end
    ep = 0;
    ef = 0;
    step();
    tile_start = 1'b0;
    tile_clear = 1'b0;
  endtask

  task automatic pix(int a, logic [ZW-1:0] z, bit zwd,
                     int c, bit te);
    bit p;
    px_valid   = 1'b1;
    px_addr    = AW'(a);
    px_z       = z;
    px_zwd     = zwd;
    depth_comp = 3'(c);
    tile_end   = te;
    p = zpass(3'(c), z, zm[a]);
    if (p && !zwd) zm[a] = z;
    if (p) ep++;
    else ef++;
    q.push_back('{cyc + 1, AW'(a), p, p & ~zwd, z});
    step();
    px_valid = 1'b0;
    tile_end = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tile_start = 0; tile_clear = 0; tile_end = 0;
    clear_val = '0; px_valid = 0; px_addr = '0;
    px_z = '0; px_zwd = 0; depth_comp = '0;
    step();
    step();
    @(negedge clock);
    chk("rst_tile_done", 32'(tile_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_px_ready", 32'(px_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    armed = 1;
    step();
    reset = 1'b0;
    step();

    // clear sweep with ignored start/end mid-way
    start(1, 32'h0);
    for (int i = 0; i < N - 1; i++) begin
      tile_start = (i == 500);
      tile_end   = (i == 500);
      tile_clear = (i == 500);
      clear_val  = (i == 500) ? 32'hFFFF_FFFF : 32'h0;
      step();
    end
    tile_start = 0; tile_end = 0; tile_clear = 0;
    @(negedge clock);
    chk("clr_last_ready", 32'(px_ready), 0);
    chk("clr_busy", 32'(busy), 1);
    step();
    @(negedge clock);
    chk("post_clr_ready", 32'(px_ready), 1);
    chk("post_clr_busy", 32'(busy), 1);
    step();

    pix(5, 32'h3F80_0000, 0, 4, 0);
    @(negedge clock);
    chk("t2_pass", 32'(res_pass), 1);
    chk("t2_wr_en", 32'(wr_en), 1);
    chk("t2_wr_addr", 32'(wr_addr), 5);
    chk("t2_wr_data", wr_data, 32'h3F80_0000);
    step();

    pix(7, 32'h4000_0000, 0, 4, 0);
    pix(7, 32'h3F00_0000, 0, 4, 0);
    @(negedge clock);
    chk("t3_pass", 32'(res_pass), 0);
    chk("t3_wr_en", 32'(wr_en), 0);
    step();

    pix(11, 32'h1234, 1, 7, 0);
    @(negedge clock);
    chk("t4_always_pass", 32'(res_pass), 1);
    chk("t4_zwd_wr_en", 32'(wr_en), 0);
    step();
    pix(11, 32'h1234, 0, 0, 0);
    @(negedge clock);
    chk("t4_never_pass", 32'(res_pass), 0);
    step();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) step();
      pix($urandom_range(0, 3), 32'($urandom_range(0, 5)),
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7), 0);
    end

    pix(20, 32'd77, 0, 7, 1);
    @(negedge clock);
    chk("t5_drain_busy", 32'(busy), 1);
    chk("t5_drain_ready", 32'(px_ready), 0);
    chk("t5_drain_done", 32'(tile_done), 0);
    step();
    @(negedge clock);
    chk("t5_done", 32'(tile_done), 1);
    chk("t5_idle_busy", 32'(busy), 0);
`ifdef ZTC_STATS_EN
    chk("stat_pass", stat_pass, ep);
    chk("stat_fail", stat_fail, ef);
`endif
    step();
    @(negedge clock);
    chk("t5_done_pulse", 32'(tile_done), 0);
    step();

    // second tile keeps the previous contents
    start(0, 32'hDEAD_BEEF);
    @(negedge clock);
    chk("noclr_ready", 32'(px_ready), 1);
    step();
    pix(5, 32'h3F80_0000, 0, 2, 0);
    @(negedge clock);
    chk("noclr_eq_pass", 32'(res_pass), 1);
    step();
    pix(7, 32'h4000_0000, 0, 5, 0);
    pix(30, 32'd1, 0, 1, 1);
    step();
    step();
    step();

    // reset during the sweep
    start(1, 32'h1234_5678);
    repeat (300) step();
    reset = 1'b1;
    step();
    clr_on = 0;
    @(negedge clock);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_wr_en", 32'(wr_en), 0);
    chk("t6_ready", 32'(px_ready), 0);
    chk("t6_done", 32'(tile_done), 0);
`ifdef ZTC_STATS_EN
    chk("t6_stat_pass", stat_pass, 0);
    chk("t6_stat_fail", stat_fail, 0);
`endif
    step();
    reset = 1'b0;
    step();
    step();
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
